// File: rtl/apb_fabric_master.sv
// Fabric-side APB3 initiator: converts a command/response handshake into APB SETUP/ACCESS
// transfers, with a PReady timeout so a hung slave cannot stall the fabric.
module apb_fabric_master #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdWrite,
    input  logic [ADDR_WIDTH-1:0] CmdAddr,
    input  logic [DATA_WIDTH-1:0] CmdWData,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [DATA_WIDTH-1:0] RspRData,
    output logic                  RspError,
    output logic                  RspTimeout,
    output logic                  PSel,
    output logic                  PEnable,
    output logic                  PWrite,
    output logic [ADDR_WIDTH-1:0] PAddr,
    output logic [DATA_WIDTH-1:0] PWData,
    input  logic [DATA_WIDTH-1:0] PRData,
    input  logic                  PReady,
    input  logic                  PSlvErr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} stateType;

    // Counter value on the last permitted stalled ACCESS cycle.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    stateType              state, stateNext;
    logic [15:0]           cnt, cntNext;
    logic                  pWriteNext;
    logic [ADDR_WIDTH-1:0] pAddrNext;
    logic [DATA_WIDTH-1:0] pWDataNext;
    logic [DATA_WIDTH-1:0] rspRDataNext;
    logic                  rspErrorNext;
    logic                  rspTimeoutNext;

    always_comb begin
        stateNext      = state;
        cntNext        = cnt;
        pWriteNext     = PWrite;
        pAddrNext      = PAddr;
        pWDataNext     = PWData;
        rspRDataNext   = RspRData;
        rspErrorNext   = RspError;
        rspTimeoutNext = RspTimeout;
        unique case (state)
            StIdle: begin
                if (CmdValid && CmdReady) begin
                    stateNext  = StSetup;
                    cntNext    = '0;
                    pWriteNext = CmdWrite;
                    pAddrNext  = CmdAddr;
                    pWDataNext = CmdWData;
                end
            end
            StSetup: stateNext = StAccess;
            StAccess: begin
                // Completion is checked first so PReady on the expiry cycle still wins.
                if (PReady) begin
                    stateNext      = StResp;
                    rspRDataNext   = (PWrite || PSlvErr) ? '0 : PRData;
                    rspErrorNext   = PSlvErr;
                    rspTimeoutNext = 1'b0;
                end else if (cnt == TimeoutLast) begin
                    stateNext      = StResp;
                    rspRDataNext   = '0;
                    rspErrorNext   = 1'b1;
                    rspTimeoutNext = 1'b1;
                end else begin
                    cntNext = cnt + 16'd1;
                end
            end
            StResp: begin
                if (RspReady) begin
                    stateNext = StIdle;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    // Handshake and APB strobes are registered from the next state so reset forces them low.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= StIdle;
            cnt        <= '0;
            CmdReady   <= 1'b0;
            RspValid   <= 1'b0;
            RspRData   <= '0;
            RspError   <= 1'b0;
            RspTimeout <= 1'b0;
            PSel       <= 1'b0;
            PEnable    <= 1'b0;
            PWrite     <= 1'b0;
            PAddr      <= '0;
            PWData     <= '0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            CmdReady   <= (stateNext == StIdle);
            RspValid   <= (stateNext == StResp);
            RspRData   <= rspRDataNext;
            RspError   <= rspErrorNext;
            RspTimeout <= rspTimeoutNext;
            PSel       <= (stateNext == StSetup) || (stateNext == StAccess);
            PEnable    <= (stateNext == StAccess);
            PWrite     <= pWriteNext;
            PAddr      <= pAddrNext;
            PWData     <= pWDataNext;
        end
    end

endmodule
